st_packet_channel_arbiter: RTL and testbench

Packet-boundary round-robin arbiter that shares one channelized Avalon-ST byte stream among NUM_IN packet sources. It tags every output beat with the index of the source that produced it on out_channel. Its output feeds the packets-to-bytes channel adapter, which consumes out_channel directly. The grant is locked from startofpacket to endofpacket, so packets are never interleaved. One registered pipeline stage on the output gives full throughput.

---
 rtl/st_packet_channel_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_st_packet_channel_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/st_packet_channel_arbiter.sv
// st_packet_channel_arbiter
//   Packet-boundary round-robin arbiter. Merges NUM_IN Avalon-ST packet
//   sources into one registered output stream and tags each beat with the
//   producing source index on out_channel. A grant is held from SOP to EOP,
//   so packets from different sources never interleave.
//
// Ports
//   clk, reset            single clock, asynchronous active-high reset
//   in_valid/in_ready     per-source handshake (in_ready is combinational)
//   in_data               source i at [i*DATA_W +: DATA_W]
//   in_startofpacket      per-source SOP
//   in_endofpacket        per-source EOP
//   out_valid/out_ready   registered output handshake
//   out_data, out_startofpacket, out_endofpacket, out_channel
//                         registered beat payload, channel = source index
//   drop_pulse            registered, one cycle per cycle of stray-beat drain
module st_packet_channel_arbiter #(
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CHANNEL_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_startofpacket,
  input  logic [NUM_IN-1:0]        in_endofpacket,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CHANNEL_W-1:0]     out_channel,
  output logic                     drop_pulse
);

  localparam int unsigned IDX_W = $clog2(NUM_IN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;
  logic [CHANNEL_W-1:0]  out_channel_q, out_channel_d;
  logic                  drop_q, drop_d;

  logic                  ld_c;
  logic [NUM_IN-1:0]     req_c;
  logic [NUM_IN-1:0]     stray_c;
  logic                  win_found_c;
  logic [IDX_W-1:0]      win_idx_c;
  logic                  sel_act_c;
  logic [IDX_W-1:0]      sel_idx_c;
  logic [DATA_W-1:0]     sel_data_c;
  logic                  sel_sop_c;
  logic                  sel_eop_c;
  logic                  xfer_c;
  logic [NUM_IN-1:0]     ready_c;

  // Output register may take a new beat when empty or being drained.
  assign ld_c    = !out_valid_q | out_ready;
  assign req_c   = in_valid & in_startofpacket;
  assign stray_c = in_valid & ~in_startofpacket;

  // Round-robin scan starting at the pointer, first SOP request wins.
  always_comb begin
    int unsigned cand;
    cand        = 0;
    win_found_c = 1'b0;
    win_idx_c   = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      cand = (32'(ptr_q) + k) % NUM_IN;
      if (!win_found_c && req_c[IDX_W'(cand)]) begin
        win_found_c = 1'b1;
        win_idx_c   = IDX_W'(cand);
      end
    end
  end

  // Locked grant overrides the scan; the scan is only meaningful in IDLE.
  assign sel_act_c  = (state_q == ST_LOCKED) | win_found_c;
  assign sel_idx_c  = (state_q == ST_LOCKED) ? grant_q : win_idx_c;
  assign sel_data_c = in_data[32'(sel_idx_c)*DATA_W +: DATA_W];
  assign sel_sop_c  = in_startofpacket[sel_idx_c];
  assign sel_eop_c  = in_endofpacket[sel_idx_c];

  // Ready fan-out: selected source follows ld; strays drain only in IDLE.
  always_comb begin
    ready_c = '0;
    if (!reset) begin
      if (state_q == ST_IDLE) begin
        ready_c = stray_c;
        if (win_found_c) begin
          ready_c[win_idx_c] = ld_c;
        end
      end else begin
        ready_c[grant_q] = ld_c;
      end
    end
  end

  assign in_ready = ready_c;
  assign xfer_c   = sel_act_c & in_valid[sel_idx_c] & ready_c[sel_idx_c];

  // Next-state: grant/pointer bookkeeping and output register loading.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    out_channel_d = out_channel_q;
    drop_d        = (state_q == ST_IDLE) & (|stray_c);

    if (xfer_c) begin
      out_valid_d   = 1'b1;
      out_data_d    = sel_data_c;
      out_sop_d     = sel_sop_c;
      out_eop_d     = sel_eop_c;
      out_channel_d = CHANNEL_W'(sel_idx_c);
      if (sel_eop_c) begin
        state_d = ST_IDLE;
        ptr_d   = (sel_idx_c == LAST_IDX) ? '0 : sel_idx_c + 1'b1;
      end else if (state_q == ST_IDLE) begin
        state_d = ST_LOCKED;
        grant_d = sel_idx_c;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Output pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_channel_q <= '0;
      drop_q        <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      out_channel_q <= out_channel_d;
      drop_q        <= drop_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign out_channel       = out_channel_q;
  assign drop_pulse        = drop_q;

endmodule

// File: tb/tb_st_packet_channel_arbiter.sv
// Testbench for st_packet_channel_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural arbiter model and a per-source packet scoreboard.
module tb_st_packet_channel_arbiter;

  localparam int unsigned NUM_IN    = 4;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CHANNEL_W = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } beat_t;

  logic                     clk;
  logic                     reset;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_ready;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_startofpacket;
  logic [NUM_IN-1:0]        in_endofpacket;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_startofpacket;
  logic                     out_endofpacket;
  logic [CHANNEL_W-1:0]     out_channel;
  logic                     drop_pulse;

  st_packet_channel_arbiter #(
    .NUM_IN   (NUM_IN),
    .DATA_W   (DATA_W),
    .CHANNEL_W(CHANNEL_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .in_startofpacket (in_startofpacket),
    .in_endofpacket   (in_endofpacket),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket  (out_endofpacket),
    .out_channel      (out_channel),
    .drop_pulse       (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Source-side state
  beat_t             srcq [NUM_IN][$];
  beat_t             expq [NUM_IN][$];
  logic [NUM_IN-1:0] vld;
  logic [NUM_IN-1:0] acc;
  int                acc_cnt [NUM_IN];
  int                pres_pct = 100;
  logic              rand_or  = 1'b0;
  int                or_pat[$];

  // Model state
  int          m_lock;
  int          m_ptr;
  logic        m_ov;
  logic [7:0]  m_d;
  logic        m_sop;
  logic        m_eop;
  int          m_ch;
  logic        m_drop;

  // Observation log
  int   log_ch[$];
  int   log_d[$];
  int   log_sop[$];
  int   log_eop[$];
  int   log_cyc[$];
  int   drop_cnt     = 0;
  int   stall_cnt    = 0;
  int   stall_rdy_hi = 0;
  logic scb_on       = 1'b0;
  int   out_beats    = 0;
  int   pushed_beats = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model + per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin : mon
    int                w;
    int                j;
    logic              ld;
    logic              stray;
    logic [NUM_IN-1:0] er;
    beat_t             eb;
    cyc++;
    if (reset) begin
      chk("reset_outputs", {out_valid, out_data, out_startofpacket, out_endofpacket,
                            out_channel, drop_pulse}, 64'd0);
      chk("reset_ready", 64'(in_ready), 64'd0);
      m_lock = -1; m_ptr = 0; m_ov = 1'b0; m_d = 8'd0;
      m_sop = 1'b0; m_eop = 1'b0; m_ch = 0; m_drop = 1'b0;
      acc = '0;
    end else begin
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
        chk("out_beat", {out_data, out_startofpacket, out_endofpacket, out_channel},
            {m_d, m_sop, m_eop, 8'(m_ch)});
      end
      chk("drop_pulse", 64'(drop_pulse), 64'(m_drop));
      if (drop_pulse) drop_cnt++;
      if (out_valid && !out_ready) begin
        stall_cnt++;
        if (in_ready[2]) stall_rdy_hi++;
      end
      if (out_valid && out_ready) begin
        log_ch.push_back(int'(out_channel));
        log_d.push_back(int'(out_data));
        log_sop.push_back(int'(out_startofpacket));
        log_eop.push_back(int'(out_endofpacket));
        log_cyc.push_back(cyc);
        if (scb_on) begin
          out_beats++;
          if (int'(out_channel) >= NUM_IN || expq[int'(out_channel)].size() == 0) begin
            chk("scb_unexpected_beat", 64'(out_channel), 64'hFF);
          end else begin
            eb = expq[int'(out_channel)].pop_front();
            chk("scb_beat", {out_data, out_startofpacket, out_endofpacket},
                {eb.d, eb.sop, eb.eop});
          end
        end
      end

      ld = !m_ov || out_ready;
      er = '0; w = -1; stray = 1'b0;
      if (m_lock < 0) begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (in_valid[i] && !in_startofpacket[i]) begin
            er[i] = 1'b1;
            stray = 1'b1;
          end
        end
        for (int k = 0; k < NUM_IN; k++) begin
          j = (m_ptr + k) % NUM_IN;
          if (w < 0 && in_valid[j] && in_startofpacket[j]) w = j;
        end
      end else begin
        w = m_lock;
      end
      if (w >= 0) er[w] = ld;
      chk("in_ready", 64'(in_ready), 64'(er));
      acc = in_valid & in_ready;

      m_drop = stray;
      if (w >= 0 && ld && in_valid[w]) begin
        m_ov  = 1'b1;
        m_d   = in_data[w*DATA_W +: DATA_W];
        m_sop = in_startofpacket[w];
        m_eop = in_endofpacket[w];
        m_ch  = w;
        if (in_endofpacket[w]) begin
          m_lock = -1;
          m_ptr  = (w + 1) % NUM_IN;
        end else if (m_lock < 0) begin
          m_lock = w;
        end
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  // Per-source Avalon-ST driver: a presented beat is held until accepted.
  task automatic drive();
    beat_t b;
    for (int i = 0; i < NUM_IN; i++) begin
      if (acc[i] && vld[i]) begin
        if (srcq[i].size() > 0) b = srcq[i].pop_front();
        acc_cnt[i]++;
        vld[i] = 1'b0;
      end
      if (!vld[i]) begin
        if (srcq[i].size() > 0 && $urandom_range(0, 99) < pres_pct) begin
          vld[i] = 1'b1;
          b = srcq[i][0];
          in_data[i*DATA_W +: DATA_W] = b.d;
          in_startofpacket[i] = b.sop;
          in_endofpacket[i]   = b.eop;
        end else begin
          in_data[i*DATA_W +: DATA_W] = 8'($urandom);
          in_startofpacket[i] = 1'($urandom);
          in_endofpacket[i]   = 1'($urandom);
        end
      end
    end
    in_valid = vld;
    if (or_pat.size() > 0) out_ready = 1'(or_pat.pop_front());
    else if (rand_or)      out_ready = ($urandom_range(0, 3) != 0);
    else                   out_ready = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic push_pkt(input int src, input int len, input int base, input bit scb);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d   = 8'(base + k);
      b.sop = (k == 0);
      b.eop = (k == len - 1);
      srcq[src].push_back(b);
      if (scb) begin
        expq[src].push_back(b);
        pushed_beats++;
      end
    end
  endtask

  task automatic push_stray(input int src, input int d);
    beat_t b;
    b.d = 8'(d); b.sop = 1'b0; b.eop = 1'b0;
    srcq[src].push_back(b);
  endtask

  task automatic flush_sources();
    for (int i = 0; i < NUM_IN; i++) begin
      srcq[i].delete();
      expq[i].delete();
      acc_cnt[i] = 0;
    end
    vld      = '0;
    in_valid = '0;
  endtask

  task automatic clear_log();
    log_ch.delete(); log_d.delete(); log_sop.delete(); log_eop.delete(); log_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush_sources();
    repeat (3) step();
    reset = 1'b0;
  endtask

  function automatic bit sources_busy();
    for (int i = 0; i < NUM_IN; i++) begin
      if (srcq[i].size() > 0 || vld[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sources_busy() || out_valid) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(n >= budget), 64'd0);
    repeat (2) step();
  endtask

  task automatic chk_log(input int idx, input int ch, input int d, input int sop, input int eop);
    if (idx >= log_ch.size()) begin
      chk("log_missing_beat", 64'(log_ch.size()), 64'(idx + 1));
    end else begin
      chk("log_beat", {8'(log_ch[idx]), 8'(log_d[idx]), 1'(log_sop[idx]), 1'(log_eop[idx])},
          {8'(ch), 8'(d), 1'(sop), 1'(eop)});
    end
  endtask

  task automatic chk_consecutive(input string nm, input int n);
    if (log_cyc.size() >= n) begin
      chk(nm, 64'(log_cyc[n-1] - log_cyc[0]), 64'(n - 1));
    end else begin
      chk(nm, 64'(log_cyc.size()), 64'(n));
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int chs[9];
    reset = 1'b1;
    vld = '0; acc = '0;
    in_valid = '0; in_data = '0; in_startofpacket = '0; in_endofpacket = '0;
    out_ready = 1'b1;
    flush_sources();
    repeat (3) step();
    reset = 1'b0;

    // Single source, 4-beat packet, then pointer must sit at 1.
    clear_log();
    push_pkt(0, 4, 8'h11, 1'b0);
    wait_drain(50);
    chk("single_len", 64'(log_ch.size()), 64'd4);
    for (int k = 0; k < 4; k++) chk_log(k, 0, 8'h11 + k, k == 0, k == 3);
    chk_consecutive("single_consec", 4);
    clear_log();
    push_pkt(0, 1, 8'h21, 1'b0);
    push_pkt(1, 1, 8'h31, 1'b0);
    wait_drain(50);
    chk_log(0, 1, 8'h31, 1, 1);
    chk_log(1, 0, 8'h21, 1, 1);

    // Contention: sources 0, 1, 3 at once right after reset.
    do_reset();
    clear_log();
    push_pkt(0, 3, 8'h00, 1'b0);
    push_pkt(1, 3, 8'h10, 1'b0);
    push_pkt(3, 3, 8'h30, 1'b0);
    wait_drain(60);
    chs = '{0, 0, 0, 1, 1, 1, 3, 3, 3};
    chk("contend_len", 64'(log_ch.size()), 64'd9);
    for (int k = 0; k < 9; k++) chk_log(k, chs[k], chs[k] * 16 + (k % 3), (k % 3) == 0, (k % 3) == 2);
    chk_consecutive("contend_consec", 9);

    // Backpressure on a 3-beat packet from source 2.
    clear_log();
    stall_cnt = 0; stall_rdy_hi = 0;
    or_pat = '{1, 0, 0, 1};
    push_pkt(2, 3, 8'h40, 1'b0);
    wait_drain(60);
    chk("bp_len", 64'(log_ch.size()), 64'd3);
    for (int k = 0; k < 3; k++) chk_log(k, 2, 8'h40 + k, k == 0, k == 2);
    chk("bp_stall_cycles", 64'(stall_cnt), 64'd2);
    chk("bp_ready_in_stall", 64'(stall_rdy_hi), 64'd0);

    // Single-beat packets on sources 1 and 2.
    do_reset();
    clear_log();
    push_pkt(1, 1, 8'hA5, 1'b0);
    push_pkt(2, 1, 8'h5A, 1'b0);
    wait_drain(40);
    chk("sbeat_len", 64'(log_ch.size()), 64'd2);
    chk_log(0, 1, 8'hA5, 1, 1);
    chk_log(1, 2, 8'h5A, 1, 1);
    chk_consecutive("sbeat_consec", 2);

    // Stray beat on source 3 while idle.
    clear_log();
    drop_cnt = 0;
    push_stray(3, 8'h77);
    wait_drain(40);
    chk("stray_drops", 64'(drop_cnt), 64'd1);
    chk("stray_no_output", 64'(log_ch.size()), 64'd0);

    // Reset in the middle of a 5-beat packet from source 1.
    for (int i = 0; i < NUM_IN; i++) acc_cnt[i] = 0;
    push_pkt(1, 5, 8'h50, 1'b0);
    begin
      int n;
      n = 0;
      while (acc_cnt[1] < 2 && n < 40) begin
        step();
        n++;
      end
      chk("midrst_wait", 64'(n >= 40), 64'd0);
    end
    chk("midrst_pre_valid", {out_valid, out_data, out_channel}, {1'b1, 8'h51, 8'd1});
    reset = 1'b1;
    #1;
    chk("midrst_outputs", {out_valid, out_data, out_startofpacket, out_endofpacket,
                           out_channel, drop_pulse}, 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd0);
    flush_sources();
    repeat (2) step();
    reset = 1'b0;
    clear_log();
    push_pkt(2, 2, 8'h70, 1'b0);
    push_pkt(0, 2, 8'h60, 1'b0);
    wait_drain(40);
    chk_log(0, 0, 8'h60, 1, 0);
    chk_log(2, 2, 8'h70, 1, 0);

    // Randomized traffic with strays, gaps and random backpressure.
    clear_log();
    scb_on = 1'b1;
    out_beats = 0; pushed_beats = 0;
    pres_pct = 60;
    rand_or = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (srcq[i].size() < 3 && $urandom_range(0, 9) < 3) begin
          if ($urandom_range(0, 9) == 0) push_stray(i, $urandom_range(0, 255));
          push_pkt(i, $urandom_range(1, 6), $urandom_range(0, 255), 1'b1);
        end
      end
      step();
    end
    rand_or = 1'b0;
    pres_pct = 100;
    wait_drain(3000);
    chk("rand_beat_count", 64'(out_beats), 64'(pushed_beats));
    for (int i = 0; i < NUM_IN; i++) chk("rand_scb_empty", 64'(expq[i].size()), 64'd0);
    scb_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
